// File: rtl/stream_pkg.sv
// stream_pkg: shared state type and ramp arithmetic for the valid/ready stream
package stream_pkg;
   typedef enum logic [1:0] {IDLE, SEND, FIN} src_state_t;
   localparam int RAMP_MAX_W = 64;
   // Full-width add; callers cast the result down to their own data width,
   // which gives the silent mod 2^W wrap.
   function automatic logic [RAMP_MAX_W-1:0] ramp_next(input logic [RAMP_MAX_W-1:0] data,
                                                       input logic [RAMP_MAX_W-1:0] step);
      return data + step;
   endfunction
endpackage

// File: rtl/stream_if.sv
// stream_if: parameterized valid/ready stream (data, valid from source; ready from sink)
interface stream_if #(parameter int WIDTH = 32);
   logic [WIDTH-1:0] data;
   logic             valid;
   logic             ready;
   modport Src (output data, output valid, input ready);
   modport Snk (input data, input valid, output ready);
endinterface

// File: rtl/stream_ramp_src.sv
// stream_ramp_src: emits a LEN-word arithmetic ramp (BASE, BASE+STEP, ...) per start, honouring backpressure
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : burst request, only looked at while idle
//   s     : stream source port (data/valid out, ready in); width taken from the interface
//   busy  : high while a burst or its completion cycle is in progress
//   done  : one-cycle pulse after the last word of a burst
module stream_ramp_src
   import stream_pkg::*;
#(
   parameter int unsigned BASE = 0,
   parameter int unsigned STEP = 1,
   parameter int unsigned LEN  = 8
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  start,
   stream_if.Src s,
   output logic  busy,
   output logic  done
);
   localparam int              W      = $bits(s.data);
   localparam int              CW     = (LEN < 1) ? 1 : $clog2(LEN + 1);
   localparam logic [W-1:0]    BASE_W = W'(BASE);
   localparam logic [W-1:0]    STEP_W = W'(STEP);
   localparam logic [CW-1:0]   LEN_C  = CW'(LEN);
   src_state_t    r_state;
   src_state_t    w_next;
   logic [W-1:0]  r_data;
   logic [CW-1:0] r_rem;
   logic          r_valid;
   logic          r_busy;
   logic          r_done;
   logic          w_xfer;
   logic          w_load;
   logic [W-1:0]  w_sum;
   assign w_sum   = W'(ramp_next(RAMP_MAX_W'(r_data), RAMP_MAX_W'(STEP_W)));
   assign s.data  = r_data;
   assign s.valid = r_valid;
   assign busy    = r_busy;
   assign done    = r_done;
   always_comb begin
      w_xfer = (r_state == SEND) && s.ready;
      w_load = (r_state == IDLE) && start && (LEN != 0);
      w_next = (r_state == IDLE) ? (start ? ((LEN == 0) ? FIN : SEND) : IDLE)
             : (r_state == SEND) ? ((w_xfer && r_rem == CW'(1)) ? FIN : SEND)
             : IDLE;
   end
   // Outputs are registered from the next state so they line up with it
   // and never see ready/start combinationally.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_data  <= '0;
         r_rem   <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_valid <= (w_next == SEND);
         r_busy  <= (w_next != IDLE);
         r_done  <= (w_next == FIN);
         if (w_load) begin
            r_data <= BASE_W;
            r_rem  <= LEN_C;
         end else if (w_xfer) begin
            r_data <= w_sum;
            r_rem  <= r_rem - CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_stream_ramp_src.sv
// tb_stream_ramp_src: directed and randomized checks of stream_ramp_src against a burst-level model
module tb_stream_ramp_src;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   int n_cmp = 0;
   int n_bad = 0;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   stream_if #(4) i4();
   logic s4, b4, d4;
   stream_ramp_src #(.BASE(14), .STEP(1), .LEN(4)) u4 (.clk(clk), .rst(rst), .start(s4), .s(i4), .busy(b4), .done(d4));
   stream_if i3();
   logic s3, b3, d3;
   stream_ramp_src #(.BASE(0), .STEP(3), .LEN(3)) u3 (.clk(clk), .rst(rst), .start(s3), .s(i3), .busy(b3), .done(d3));
   stream_if i0();
   logic s0, b0, d0;
   stream_ramp_src #(.BASE(0), .STEP(1), .LEN(0)) u0 (.clk(clk), .rst(rst), .start(s0), .s(i0), .busy(b0), .done(d0));
   stream_if #(16) i8();
   logic s8, b8, d8;
   stream_ramp_src #(.BASE(5), .STEP(7), .LEN(8)) u8 (.clk(clk), .rst(rst), .start(s8), .s(i8), .busy(b8), .done(d8));
   logic sw;
   stream_if ia();
   logic ba, da;
   stream_ramp_src #(.BASE(0), .STEP(1000), .LEN(2)) ua (.clk(clk), .rst(rst), .start(sw), .s(ia), .busy(ba), .done(da));
   stream_if #(10) ib();
   logic bb, db;
   stream_ramp_src #(.BASE(0), .STEP(1000), .LEN(2)) ub (.clk(clk), .rst(rst), .start(sw), .s(ib), .busy(bb), .done(db));
   stream_if #(10) ic();
   logic bc, dc;
   stream_ramp_src #(.BASE(1000), .STEP(1000), .LEN(2)) uc (.clk(clk), .rst(rst), .start(sw), .s(ic), .busy(bc), .done(dc));
   stream_if #(8) ir();
   logic sr, br, dr;
   stream_ramp_src #(.BASE(200), .STEP(37), .LEN(5)) ur (.clk(clk), .rst(rst), .start(sr), .s(ir), .busy(br), .done(dr));
   initial begin
      int nx, nd, m_sent;
      bit m_act, m_fin, m_rstd;
      logic [3:0] w4 [4];
      w4 = '{4'd14, 4'd15, 4'd0, 4'd1};
      rst = 1'b1;
      {s4, s3, s0, s8, sw, sr} = '0;
      i4.ready = 1'b1; i3.ready = 1'b1; i0.ready = 1'b1; i8.ready = 1'b1;
      ia.ready = 1'b1; ib.ready = 1'b1; ic.ready = 1'b1; ir.ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_valid", i4.valid, 0);
      chk("rst_data", ic.data, 0);
      chk("rst_busy", b4, 0);
      chk("rst_done", d4, 0);
      rst = 1'b0;
      // wrap-around on a 4-bit stream
      @(negedge clk) s4 = 1'b1;
      @(negedge clk) s4 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("wrap_valid", i4.valid, 1);
         chk("wrap_data", i4.data, w4[k]);
         chk("wrap_busy", b4, 1);
         @(negedge clk);
      end
      chk("wrap_done", d4, 1);
      chk("wrap_fin_valid", i4.valid, 0);
      chk("wrap_fin_busy", b4, 1);
      @(negedge clk);
      chk("wrap_idle_busy", b4, 0);
      chk("wrap_idle_done", d4, 0);
      // backpressure: two stall cycles after the first transfer
      @(negedge clk) s3 = 1'b1;
      @(negedge clk) s3 = 1'b0;
      chk("bp_w0", i3.data, 0);
      @(negedge clk);
      chk("bp_w1", i3.data, 3);
      i3.ready = 1'b0;
      @(negedge clk);
      chk("bp_stall_data", i3.data, 3);
      chk("bp_stall_valid", i3.valid, 1);
      @(negedge clk);
      chk("bp_stall2_data", i3.data, 3);
      chk("bp_stall2_valid", i3.valid, 1);
      i3.ready = 1'b1;
      @(negedge clk);
      chk("bp_w2", i3.data, 6);
      chk("bp_w2_valid", i3.valid, 1);
      @(negedge clk);
      chk("bp_done", d3, 1);
      chk("bp_fin_valid", i3.valid, 0);
      // zero length
      @(negedge clk) s0 = 1'b1;
      @(negedge clk) s0 = 1'b0;
      chk("zl_done", d0, 1);
      chk("zl_valid", i0.valid, 0);
      chk("zl_busy", b0, 1);
      @(negedge clk);
      chk("zl_done_gone", d0, 0);
      chk("zl_idle_busy", b0, 0);
      chk("zl_idle_valid", i0.valid, 0);
      s0 = 1'b1;
      @(negedge clk) s0 = 1'b0;
      chk("zl_restart_done", d0, 1);
      // start during SEND and during FIN is ignored
      @(negedge clk) s8 = 1'b1;
      @(negedge clk) s8 = 1'b0;
      nx = 0; nd = 0;
      for (int c = 1; c <= 14; c++) begin
         if (i8.valid) begin
            chk("sb_data", i8.data, 64'(16'(5 + 7 * nx)));
            nx++;
         end
         if (d8) nd++;
         s8 = (c == 3 || c == 9);
         @(negedge clk);
      end
      s8 = 1'b0;
      chk("sb_words", nx, 8);
      chk("sb_dones", nd, 1);
      // reset after two words
      @(negedge clk) s8 = 1'b1;
      @(negedge clk) s8 = 1'b0;
      chk("mr_w0", i8.data, 5);
      @(negedge clk);
      chk("mr_w1", i8.data, 12);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mr_valid", i8.valid, 0);
      chk("mr_busy", b8, 0);
      chk("mr_data", i8.data, 0);
      chk("mr_done", d8, 0);
      nd = 0;
      repeat (10) begin
         if (d8 || i8.valid) nd++;
         @(negedge clk);
      end
      chk("mr_quiet", nd, 0);
      s8 = 1'b1;
      @(negedge clk) s8 = 1'b0;
      chk("mr_restart_valid", i8.valid, 1);
      chk("mr_restart_data", i8.data, 5);
      repeat (12) @(negedge clk);
      // same parameters on 32- and 10-bit streams
      sw = 1'b1;
      @(negedge clk) sw = 1'b0;
      chk("w32_w0", ia.data, 0);
      chk("w10_w0", ib.data, 0);
      chk("w10b_w0", ic.data, 1000);
      @(negedge clk);
      chk("w32_w1", ia.data, 1000);
      chk("w10_w1", ib.data, 1000);
      chk("w10b_w1", ic.data, 976);
      @(negedge clk);
      chk("w10_done", db, 1);
      // randomized start/ready/reset against a burst-level model
      m_act = 0; m_fin = 0; m_sent = 0; m_rstd = 0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         chk("rnd_valid", ir.valid, m_act);
         chk("rnd_busy", br, m_act | m_fin);
         chk("rnd_done", dr, m_fin);
         if (m_act) chk("rnd_data", ir.data, (200 + m_sent * 37) % 256);
         if (m_rstd) chk("rnd_rst_data", ir.data, 0);
         rst = ($urandom_range(99) == 0);
         sr = ($urandom_range(3) == 0);
         ir.ready = ($urandom_range(2) != 0);
         @(posedge clk);
         m_rstd = rst;
         if (rst) begin
            m_act = 0; m_fin = 0; m_sent = 0;
         end else if (m_fin) begin
            m_fin = 0;
         end else if (m_act) begin
            if (ir.ready) begin
               m_sent++;
               if (m_sent == 5) begin
                  m_act = 0; m_fin = 1;
               end
            end
         end else if (sr) begin
            m_act = 1; m_sent = 0;
         end
      end
      rst = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
